// File: rtl/ir_nec_if.sv
// ---------------------------------------------------------------------------
// Module  : ir_nec_if
// Brief   : Request/status bundle between an NEC IR transmitter and its user.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ir_nec_if;
  logic        i_send;
  logic        i_repeat;
  logic [15:0] i_custom;
  logic [7:0]  i_key;
  logic        o_irda_txd;
  logic        o_envelope;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_send, i_repeat, i_custom, i_key,
    input  o_irda_txd, o_envelope, o_busy, o_done
  );

  modport slave (
    input  i_send, i_repeat, i_custom, i_key,
    output o_irda_txd, o_envelope, o_busy, o_done
  );
endinterface

`default_nettype wire

// File: rtl/ir_nec_transmit.sv
// ---------------------------------------------------------------------------
// Module  : ir_nec_transmit
// Brief   : NEC IR transmitter, frame {~key,key,custom} LSB first, repeat codes,
//           optional carrier modulation of the marks.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ir_nec_transmit #(
  parameter int UNIT_CYCLES    = 28125,
  parameter int CARRIER_PERIOD = 1316,
  parameter int CARRIER_HIGH   = 658,
  parameter int FRAME_UNITS    = 192,
  parameter bit MODULATE       = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  ir_nec_if.slave   bus
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;
  localparam logic [UW-1:0] c_unit_last  = UW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] c_car_last   = CW'(CARRIER_PERIOD - 1);
  localparam logic [CW:0]   c_car_high   = (CW+1)'(CARRIER_HIGH);
  localparam logic [7:0]    c_frame_last = 8'(FRAME_UNITS - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LEAD_MARK  = 4'd1,
    S_LEAD_SPACE = 4'd2,
    S_BIT_MARK   = 4'd3,
    S_BIT_SPACE  = 4'd4,
    S_STOP_MARK  = 4'd5,
    S_GAP        = 4'd6,
    S_REP_MARK   = 4'd7,
    S_REP_SPACE  = 4'd8,
    S_REP_STOP   = 4'd9
  } state_t;

  state_t          r_state;
  logic [UW-1:0]   r_unit_cnt;
  logic [4:0]      r_units;
  logic [7:0]      r_frame_cnt;
  logic [4:0]      r_bit_idx;
  logic [31:0]     r_frame;
  logic [CW-1:0]   r_car_cnt;
  logic            r_envelope;
  logic            r_txd;
  logic            r_busy;
  logic            r_done;

  logic            w_unit_end;
  logic            w_state_end;
  logic            w_gap_end;
  logic [4:0]      w_len_m1;
  logic [CW-1:0]   w_car_next;
  logic            w_car_on;

  assign w_unit_end  = (r_unit_cnt == c_unit_last);
  assign w_state_end = w_unit_end && (r_units == w_len_m1);
  assign w_gap_end   = w_unit_end && (r_frame_cnt == c_frame_last);
  assign w_car_next  = (r_car_cnt == c_car_last) ? '0 : r_car_cnt + 1'b1;
  assign w_car_on    = MODULATE ? ({1'b0, w_car_next} < c_car_high) : 1'b1;

  // State lengths in units, minus one
  always_comb begin
    w_len_m1 = 5'd0;
    case (r_state)
      S_LEAD_MARK:  w_len_m1 = 5'd15;
      S_LEAD_SPACE: w_len_m1 = 5'd7;
      S_BIT_SPACE:  w_len_m1 = r_frame[r_bit_idx] ? 5'd2 : 5'd0;
      S_REP_MARK:   w_len_m1 = 5'd15;
      S_REP_SPACE:  w_len_m1 = 5'd3;
      default:      w_len_m1 = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_unit_cnt  <= '0;
      r_units     <= '0;
      r_frame_cnt <= '0;
      r_bit_idx   <= '0;
      r_frame     <= '0;
      r_car_cnt   <= '0;
      r_envelope  <= 1'b0;
      r_txd       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // In-state housekeeping; transitions below override what they need
      if (r_state != S_IDLE) begin
        r_unit_cnt  <= w_unit_end ? '0 : r_unit_cnt + 1'b1;
        r_frame_cnt <= r_frame_cnt + {7'd0, w_unit_end};
        if (w_unit_end && r_state != S_GAP)
          r_units <= r_units + 1'b1;
        r_car_cnt   <= w_car_next;
        r_txd       <= r_envelope & w_car_on;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.i_send) begin
            r_frame     <= {~bus.i_key, bus.i_key, bus.i_custom};
            r_bit_idx   <= '0;
            r_frame_cnt <= '0;
            r_units     <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_LEAD_MARK;
            r_envelope  <= 1'b1;
            r_txd       <= 1'b1;
            r_car_cnt   <= '0;
          end
        end
        S_LEAD_MARK, S_BIT_MARK, S_REP_MARK, S_REP_STOP, S_STOP_MARK: begin
          if (w_state_end) begin
            r_units    <= '0;
            r_envelope <= 1'b0;
            r_txd      <= 1'b0;
            case (r_state)
              S_LEAD_MARK: r_state <= S_LEAD_SPACE;
              S_BIT_MARK:  r_state <= S_BIT_SPACE;
              S_REP_MARK:  r_state <= S_REP_SPACE;
              default:     r_state <= S_GAP;
            endcase
          end
        end
        S_LEAD_SPACE, S_BIT_SPACE, S_REP_SPACE: begin
          if (w_state_end) begin
            r_units    <= '0;
            r_envelope <= 1'b1;
            r_txd      <= 1'b1;
            r_car_cnt  <= '0;
            if (r_state == S_REP_SPACE)
              r_state <= S_REP_STOP;
            else if (r_state == S_LEAD_SPACE)
              r_state <= S_BIT_MARK;
            else if (r_bit_idx == 5'd31)
              r_state <= S_STOP_MARK;
            else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_state   <= S_BIT_MARK;
            end
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_frame_cnt <= '0;
            r_units     <= '0;
            r_car_cnt   <= '0;
            if (bus.i_repeat) begin
              r_state    <= S_REP_MARK;
              r_envelope <= 1'b1;
              r_txd      <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
              r_bit_idx <= '0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_irda_txd = r_txd;
  assign bus.o_envelope = r_envelope;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ir_nec_transmit.sv
// ---------------------------------------------------------------------------
// Module  : tb_ir_nec_transmit
// Brief   : Directed bench for ir_nec_transmit with envelope run-length monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ir_nec_transmit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  ir_nec_if bus();
  ir_nec_if bus0();

  // Second instance without modulation sees the same stimulus
  assign bus0.i_send   = bus.i_send;
  assign bus0.i_repeat = bus.i_repeat;
  assign bus0.i_custom = bus.i_custom;
  assign bus0.i_key    = bus.i_key;

  ir_nec_transmit #(
    .UNIT_CYCLES(8), .CARRIER_PERIOD(4), .CARRIER_HIGH(2),
    .FRAME_UNITS(192), .MODULATE(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ir_nec_transmit #(
    .UNIT_CYCLES(8), .CARRIER_PERIOD(4), .CARRIER_HIGH(2),
    .FRAME_UNITS(192), .MODULATE(1'b0)
  ) dut_m0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Envelope monitor: run lengths of marks and spaces, carrier pulses per mark
  int   mark_len[$];
  int   mark_start[$];
  int   mark_pulses[$];
  int   space_len[$];
  int   run, pulses, done_cnt, done_cyc, busy_gap, txd_sp, mod0_mis;
  bit   seen_mark, in_frame;
  logic prev_env = 1'b0, prev_txd = 1'b0;
  int   clr_gen = 0, seen_gen = 0;

  initial forever begin
    @(negedge clk);
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      mark_len.delete(); mark_start.delete(); mark_pulses.delete(); space_len.delete();
      run = 0; pulses = 0; done_cnt = 0; done_cyc = 0; busy_gap = 0;
      txd_sp = 0; mod0_mis = 0; seen_mark = 0; in_frame = 0;
    end
    if (bus0.o_irda_txd !== bus0.o_envelope) mod0_mis++;
    if (!bus.o_envelope && bus.o_irda_txd) txd_sp++;
    if (bus.o_envelope && !prev_env) begin
      if (seen_mark) space_len.push_back(run);
      seen_mark = 1;
      in_frame  = 1;
      mark_start.push_back(cyc);
      pulses = 0;
      run = 1;
    end else if (!bus.o_envelope && prev_env) begin
      mark_len.push_back(run);
      mark_pulses.push_back(pulses);
      run = 1;
    end else begin
      run++;
    end
    if (bus.o_envelope && bus.o_irda_txd && !prev_txd) pulses++;
    if (bus.o_done) begin
      done_cnt++;
      done_cyc = cyc;
      in_frame = 0;
    end else if (in_frame && !bus.o_busy) begin
      busy_gap++;
    end
    prev_env = bus.o_envelope;
    prev_txd = bus.o_irda_txd;
  end

  task automatic clear_monitor();
    clr_gen++;
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] k, input logic [15:0] c);
    @(posedge clk);
    #1;
    bus.i_key    = k;
    bus.i_custom = c;
    bus.i_send   = 1'b1;
    @(posedge clk);
    #1;
    bus.i_send   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) check({tag, "_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Frame for key 0x0F / custom 0x00FF is 32'hF00F00FF
  task automatic check_frame(input string tag);
    logic [31:0] expd;
    logic [31:0] dec;
    int          mark_errs;
    int          space_errs;
    expd       = 32'hF00F00FF;
    dec        = '0;
    mark_errs  = 0;
    space_errs = 0;
    for (int i = 1; i < 34; i++)
      if (mark_len[i] != 8) mark_errs++;
    for (int i = 0; i < 32; i++) begin
      if (space_len[1+i] == 24) dec[i] = 1'b1;
      else if (space_len[1+i] != 8) space_errs++;
    end
    check({tag, "_mark_cnt"},   mark_len.size(),  34);
    check({tag, "_space_cnt"},  space_len.size(), 33);
    check({tag, "_lead_mark"},  mark_len[0],      128);
    check({tag, "_lead_space"}, space_len[0],     64);
    check({tag, "_bit_marks"},  mark_errs,        0);
    check({tag, "_bit_spaces"}, space_errs,       0);
    check({tag, "_data"},       dec,              expd);
    check({tag, "_done_cnt"},   done_cnt,         1);
    check({tag, "_done_time"},  done_cyc - mark_start[0], 1536);
    check({tag, "_busy_gap"},   busy_gap,         0);
    check({tag, "_lead_pulses"}, mark_pulses[0],  32);
    check({tag, "_bit_pulses"}, mark_pulses[1],   2);
    check({tag, "_txd_space"},  txd_sp,           0);
    check({tag, "_mod0_txd"},   mod0_mis,         0);
  endtask

  initial begin
    int n;
    bus.i_send   = 1'b0;
    bus.i_repeat = 1'b0;
    bus.i_custom = '0;
    bus.i_key    = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_outs",    {28'd0, bus.o_irda_txd, bus.o_envelope, bus.o_busy, bus.o_done}, 32'd0);
    check("reset_outs_m0", {28'd0, bus0.o_irda_txd, bus0.o_envelope, bus0.o_busy, bus0.o_done}, 32'd0);

    // Idle: data inputs wiggle, no send
    clear_monitor();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      bus.i_key    = 8'(i * 37);
      bus.i_custom = 16'(i * 4099);
    end
    @(negedge clk);
    check("idle_marks", mark_len.size() + mark_start.size(), 32'd0);
    check("idle_outs",  {28'd0, bus.o_irda_txd, bus.o_envelope, bus.o_busy, bus.o_done}, 32'd0);

    // Basic frame, with an ignored send request mid-frame
    clear_monitor();
    send_frame(8'h0F, 16'h00FF);
    repeat (300) @(posedge clk);
    #1;
    bus.i_key  = 8'h13;
    bus.i_send = 1'b1;
    @(posedge clk);
    #1 bus.i_send = 1'b0;
    wait_done("f1", 3000);
    check_frame("f1");

    // Three repeat codes, then release
    clear_monitor();
    bus.i_repeat = 1'b1;
    send_frame(8'h0F, 16'h00FF);
    n = 0;
    while (mark_start.size() < 39 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    if (mark_start.size() < 39) check("rep_timeout", 32'd1, 32'd0);
    #1 bus.i_repeat = 1'b0;
    wait_done("rep", 3000);
    check("rep_mark_cnt",  mark_len.size(), 40);
    check("rep1_mark",     mark_len[34],    128);
    check("rep1_space",    space_len[34],   32);
    check("rep1_stop",     mark_len[35],    8);
    check("rep3_stop",     mark_len[39],    8);
    check("rep1_start",    mark_start[34] - mark_start[0],  1536);
    check("rep2_start",    mark_start[36] - mark_start[34], 1536);
    check("rep3_start",    mark_start[38] - mark_start[36], 1536);
    check("rep_done_time", done_cyc - mark_start[38], 1536);
    check("rep_done_cnt",  done_cnt, 1);
    check("rep_busy_gap",  busy_gap, 0);
    check("rep_mod0_txd",  mod0_mis, 0);

    // Asynchronous reset inside the first bit space (a '1' bit, 24 clocks)
    clear_monitor();
    send_frame(8'h0F, 16'h00FF);
    repeat (205) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_outs",    {28'd0, bus.o_irda_txd, bus.o_envelope, bus.o_busy, bus.o_done}, 32'd0);
    check("rst_async_outs_m0", {28'd0, bus0.o_irda_txd, bus0.o_envelope, bus0.o_busy, bus0.o_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_release_outs", {28'd0, bus.o_irda_txd, bus.o_envelope, bus.o_busy, bus.o_done}, 32'd0);
    clear_monitor();
    send_frame(8'h0F, 16'h00FF);
    wait_done("rst", 3000);
    check_frame("rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
